config_stream_loader: RTL and testbench
=======================================

// Module: config_stream_loader
// PURPOSE
//  Synthesizable driver for the fabric's serial configuration chain (config_in/config_clk/config_en).
//  Accepts the bitstream as WORD_WIDTH-bit words over a valid/ready handshake and shifts it in LSB-first.
//  Captures config_out (previous chain contents) as readback words.
//  Sits between the host/bitstream memory and the top-level mesh; replaces bench-driven configuration.
// PARAMETERS
//  CONFIG_WIDTH  4651  total chain bits (IO+CLB+CX+SWBX for 3x3 mesh)
//  WORD_WIDTH    32    bits per input/readback word
//  CLK_DIV       2     clk cycles per config_clk phase (low and high each), >=1
// PORTS
//  clk             in   1           system clock
//  rst             in   1           asynchronous reset, active-high
//  start           in   1           begin a load; sampled only in IDLE
//  abort           in   1           synchronous abort, any state
//  word_data       in   WORD_WIDTH  bitstream word; bit j of word k = chain bit k*WORD_WIDTH+j
//  word_valid      in   1           word_data valid
//  word_ready      out  1           loader can accept word
//  config_in       out  1           serial data to chain
//  config_clk      out  1           chain shift clock
//  config_en       out  1           chain shift enable
//  config_out      in   1           serial data from chain tail
//  readback_data   out  WORD_WIDTH  captured chain-out word
//  readback_valid  out  1           one-cycle pulse, readback_data valid
//  busy            out  1           high from start accept until done
//  done            out  1           one-cycle pulse at end of load
// BEHAVIOUR
//  Reset (async): all outputs 0. NUM_WORDS = ceil(CONFIG_WIDTH/WORD_WIDTH); last word uses low bits only; upper bits are ignored.
//  FSM: IDLE -> LOAD -> SHIFT_LO <-> SHIFT_HI -> (LOAD | FINISH) -> IDLE.
//  IDLE: start=1 -> LOAD next cycle; busy=1, config_en=1, bit counter 0.
//  LOAD: word_ready=1, config_clk=0. Accept on word_valid&&word_ready -> SHIFT_LO next cycle with config_in=bit0 of word.
//   Missing word_valid stalls indefinitely: config_clk held 0, config_en held 1, no edges.
//  SHIFT_LO: CLK_DIV cycles, config_clk=0, config_in stable. config_out sampled in its last cycle (before the rising edge).
//  SHIFT_HI: CLK_DIV cycles, config_clk=1, config_in unchanged. On exit the bit counter increments.
//   Bits remain in word and stream -> SHIFT_LO with next bit.
//   Word exhausted, stream not -> LOAD.
//   Stream exhausted -> FINISH.
//  Exactly CONFIG_WIDTH rising config_clk edges per load; config_in only changes while config_clk=0.
//  FINISH: one cycle; config_clk=0, config_en=0, done=1, busy=0 next cycle; -> IDLE.
//  Readback: sampled bits are packed LSB-first. readback_valid pulses the cycle after the WORD_WIDTH-th sample of each word.
//   The final partial word pulses in FINISH, with unfilled upper bits 0. No backpressure.
//  abort=1: next cycle IDLE; config_en/config_clk/word_ready/busy=0; no done, no partial readback pulse.
//   abort has priority over start and over a same-cycle word accept.
//  start while busy is ignored. Mid-load rst or abort leaves fabric contents undefined; the host reloads.
//  Per-bit cost 2*CLK_DIV clk cycles. Minimum load time: CONFIG_WIDTH*2*CLK_DIV + NUM_WORDS + 2 cycles.
// STRUCTURE
//  Shared include config_params.vh: CONFIG_WIDTH derivation from MESH_SIZE_X/Y, CLB_NUM_BLE, SWBX_WIDTH, IO_WIDTH;
//   state encodings; NUM_WORDS/last-word-bits as localparams.
//  Top: FSM, phase counter ($clog2(CLK_DIV)+1), bit counter ($clog2(CONFIG_WIDTH+1)).
//  Sub-module config_word_shifter: PISO for word_data plus SIPO for config_out, load/shift/flush controls.
// TESTING  (CONFIG_WIDTH=40, WORD_WIDTH=16, CLK_DIV=2; chain model = 40-bit shift reg clocked by config_clk when config_en)
//  1 rst pulse mid-sim -> all outputs 0 same cycle; IDLE; word_ready=0.
//  2 start; words 16'hA5C3, 16'h0F0F, 16'hFF81 -> exactly 40 config_clk edges.
//    Chain model holds 40'h81_0F0F_A5C3; done once; busy falls after done; 163 cycles, start to done.
//  3 As 2, word_valid low 10 cycles before word 2 -> config_clk stays 0, config_en 1, no extra edges; final chain identical.
//  4 Chain preloaded 40'h12_3456_789A -> readback 16'h789A, 16'h3456, 16'h0012 (third pulses in FINISH).
//  5 abort after 5th config_clk edge -> IDLE next cycle, config_en=0, no done; new start + full load then passes check 2.
//  6 start while busy and word_valid in SHIFT states -> ignored, word_ready=0, bitstream unaffected.

Source files
------------

// File: rtl/config_stream_loader_pkg.sv
// Shared types and helpers for the serial configuration-chain loader.
package config_stream_loader_pkg;

  // Full 3x3 mesh chain length (IO + CLB + CX + SWBX bits).
  localparam int unsigned DEF_CONFIG_WIDTH = 4651;
  localparam int unsigned DEF_WORD_WIDTH   = 32;
  localparam int unsigned DEF_CLK_DIV      = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_FINISH   = 3'd4
  } state_e;

  // Per-cycle controls from the sequencer to the word shifter.
  typedef struct packed {
    logic clear;
    logic load;
    logic sample;
    logic advance;
    logic flush;
  } shift_ctrl_t;

  function automatic int unsigned num_words(input int unsigned cw, input int unsigned ww);
    return (cw + ww - 1) / ww;
  endfunction

  function automatic int unsigned last_word_bits(input int unsigned cw, input int unsigned ww);
    return cw - (num_words(cw, ww) - 1) * ww;
  endfunction

endpackage

// File: rtl/config_word_shifter.sv
// PISO for outgoing bitstream words and SIPO packing chain-out samples into readback words.
module config_word_shifter
  import config_stream_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  shift_ctrl_t           ctrl,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  config_out,
  output logic                  config_in,
  output logic                  word_last_c,
  output logic [WORD_WIDTH-1:0] readback_data,
  output logic                  readback_valid
);

  localparam int unsigned IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  logic [WORD_WIDTH-1:0] piso_q;
  logic [WORD_WIDTH-1:0] sipo_q;
  logic [IDX_W-1:0]      idx_q;

  assign config_in   = piso_q[0];
  assign word_last_c = (idx_q == IDX_W'(WORD_WIDTH - 1));

  // idx_q is the bit position within the current word, shared by both directions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      piso_q         <= '0;
      sipo_q         <= '0;
      idx_q          <= '0;
      readback_data  <= '0;
      readback_valid <= 1'b0;
    end else if (ctrl.clear) begin
      piso_q         <= '0;
      sipo_q         <= '0;
      idx_q          <= '0;
      readback_valid <= 1'b0;
    end else begin
      readback_valid <= 1'b0;
      if (ctrl.load) begin
        piso_q <= word_data;
        idx_q  <= '0;
      end else if (ctrl.advance) begin
        piso_q <= piso_q >> 1;
        idx_q  <= idx_q + IDX_W'(1);
      end
      if (ctrl.sample) begin
        if (word_last_c) begin
          readback_data  <= sipo_q | (WORD_WIDTH'(config_out) << (WORD_WIDTH - 1));
          readback_valid <= 1'b1;
          sipo_q         <= '0;
        end else begin
          sipo_q[idx_q] <= config_out;
        end
      end else if (ctrl.flush) begin
        readback_data  <= sipo_q;
        readback_valid <= 1'b1;
        sipo_q         <= '0;
      end
    end
  end

endmodule

// File: rtl/config_stream_loader.sv
// Drives the fabric configuration chain from a word stream, LSB-first, and returns the
// displaced chain contents as readback words.
module config_stream_loader
  import config_stream_loader_pkg::*;
#(
  parameter int unsigned CONFIG_WIDTH = DEF_CONFIG_WIDTH,
  parameter int unsigned WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int unsigned CLK_DIV      = DEF_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_in,
  output logic                  config_clk,
  output logic                  config_en,
  input  logic                  config_out,
  output logic [WORD_WIDTH-1:0] readback_data,
  output logic                  readback_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned LAST_BITS   = last_word_bits(CONFIG_WIDTH, WORD_WIDTH);
  localparam bit          HAS_PARTIAL = (LAST_BITS != WORD_WIDTH);
  localparam int unsigned PH_W        = $clog2(CLK_DIV) + 1;
  localparam int unsigned BC_W        = $clog2(CONFIG_WIDTH + 1);

  state_e           state_q, state_c;
  logic [PH_W-1:0]  phase_q;
  logic [BC_W-1:0]  bit_cnt_q;
  logic             phase_last_c, stream_last_c, word_last_c;
  shift_ctrl_t      ctrl_c;
  logic             busy_c, en_c, clk_c, ready_c, done_c;

  assign phase_last_c  = (phase_q == PH_W'(CLK_DIV - 1));
  assign stream_last_c = (bit_cnt_q == BC_W'(CONFIG_WIDTH - 1));

  // Next state, shifter controls and next values of the registered outputs.
  always_comb begin
    state_c = state_q;
    ctrl_c  = '0;
    busy_c  = 1'b0;
    en_c    = 1'b0;
    clk_c   = 1'b0;
    ready_c = 1'b0;
    done_c  = 1'b0;

    case (state_q)
      ST_IDLE: if (start) state_c = ST_LOAD;
      ST_LOAD: begin
        if (word_valid) begin
          state_c     = ST_SHIFT_LO;
          ctrl_c.load = 1'b1;
        end
      end
      ST_SHIFT_LO: begin
        if (phase_last_c) begin
          state_c       = ST_SHIFT_HI;
          ctrl_c.sample = 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (phase_last_c) begin
          if (stream_last_c) begin
            state_c      = ST_FINISH;
            ctrl_c.flush = HAS_PARTIAL;
          end else if (word_last_c) begin
            state_c = ST_LOAD;
          end else begin
            state_c        = ST_SHIFT_LO;
            ctrl_c.advance = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        state_c      = ST_IDLE;
        ctrl_c.clear = 1'b1;
      end
      default: state_c = ST_IDLE;
    endcase

    // Abort wins over start, word accept and the end-of-load flush.
    if (abort) begin
      state_c      = ST_IDLE;
      ctrl_c       = '0;
      ctrl_c.clear = 1'b1;
    end

    busy_c  = (state_c != ST_IDLE);
    en_c    = (state_c inside {ST_LOAD, ST_SHIFT_LO, ST_SHIFT_HI});
    clk_c   = (state_c == ST_SHIFT_HI);
    ready_c = (state_c == ST_LOAD);
    done_c  = (state_c == ST_FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      bit_cnt_q  <= '0;
      busy       <= 1'b0;
      config_en  <= 1'b0;
      config_clk <= 1'b0;
      word_ready <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q <= state_c;
      if ((state_c == state_q) && (state_q inside {ST_SHIFT_LO, ST_SHIFT_HI}))
        phase_q <= phase_q + PH_W'(1);
      else
        phase_q <= '0;
      if (state_c == ST_IDLE)
        bit_cnt_q <= '0;
      else if ((state_q == ST_SHIFT_HI) && phase_last_c)
        bit_cnt_q <= bit_cnt_q + BC_W'(1);
      busy       <= busy_c;
      config_en  <= en_c;
      config_clk <= clk_c;
      word_ready <= ready_c;
      done       <= done_c;
    end
  end

  config_word_shifter #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_shifter (
    .clk            (clk),
    .rst            (rst),
    .ctrl           (ctrl_c),
    .word_data      (word_data),
    .config_out     (config_out),
    .config_in      (config_in),
    .word_last_c    (word_last_c),
    .readback_data  (readback_data),
    .readback_valid (readback_valid)
  );

endmodule

// File: tb/tb_config_stream_loader.sv
// Bench for config_stream_loader: 40-bit chain model, randomized bitstreams and preloads.
module tb_config_stream_loader;

  localparam int CW = 40;
  localparam int WW = 16;
  localparam int CD = 2;
  localparam int NW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [WW-1:0] word_data = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic          config_in;
  logic          config_clk;
  logic          config_en;
  logic          config_out;
  logic [WW-1:0] readback_data;
  logic          readback_valid;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  config_stream_loader #(
    .CONFIG_WIDTH(CW),
    .WORD_WIDTH  (WW),
    .CLK_DIV     (CD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .word_data      (word_data),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .config_in      (config_in),
    .config_clk     (config_clk),
    .config_en      (config_en),
    .config_out     (config_out),
    .readback_data  (readback_data),
    .readback_valid (readback_valid),
    .busy           (busy),
    .done           (done)
  );

  // Chain model: shift register clocked by config_clk, head at bit 39, tail at bit 0.
  logic [CW-1:0] chain = '0;
  logic [CW-1:0] preload_val = '0;
  logic          preload_stb = 1'b0;
  int            edge_cnt = 0;

  always @(posedge config_clk or posedge preload_stb) begin
    if (preload_stb) chain <= preload_val;
    else begin
      edge_cnt <= edge_cnt + 1;
      if (config_en) chain <= {config_in, chain[CW-1:1]};
    end
  end

  assign config_out = chain[0];

  task automatic do_preload(input logic [CW-1:0] v);
    preload_val = v;
    preload_stb = 1'b1;
    #1;
    preload_stb = 1'b0;
  endtask

  // One full load with optional stall and busy-time pokes; checks chain, timing and readback.
  task automatic run_load(input string tag, input logic [47:0] stream, input logic [CW-1:0] pre,
                          input int stall_word, input int stall_len, input bit poke);
    int cyc, widx, stall_left, done_cnt, done_cyc, rb_idx, e0, bad_in, bad_stall, bad_hi, extra;
    logic prev_in, fire, stalling, finished;
    logic [47:0] pre_ext;
    logic [WW-1:0] rb_exp;
    cyc = 0; widx = 0; stall_left = stall_len; done_cnt = 0; done_cyc = -1; rb_idx = 0;
    bad_in = 0; bad_stall = 0; bad_hi = 0; extra = 0; finished = 1'b0;
    pre_ext = {8'h00, pre};
    do_preload(pre);
    e0 = edge_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prev_in = config_in;
    while (!finished && cyc < 2000) begin
      stalling = 1'b0;
      if (widx < NW) begin
        if (widx == stall_word && stall_left > 0 && word_ready) begin
          word_valid = 1'b0; stall_left--; stalling = 1'b1;
        end else begin
          word_valid = 1'b1; word_data = stream[widx*WW +: WW];
        end
      end else begin
        word_valid = 1'($urandom); word_data = WW'($urandom);
      end
      if (stalling && (config_clk || !config_en)) bad_stall++;
      start = (poke && config_en && !word_ready) ? 1'($urandom) : 1'b0;
      fire = word_valid && word_ready;
      @(posedge clk); #1;
      cyc++;
      if (fire) widx++;
      if (config_clk && config_in !== prev_in) bad_in++;
      prev_in = config_in;
      if (config_clk && word_ready) bad_hi++;
      if (readback_valid) begin
        if (rb_idx < NW) begin
          rb_exp = pre_ext[rb_idx*WW +: WW];
          n_checks++;
          if (readback_data !== rb_exp)
            $display("FAIL %s readback[%0d]: got %h want %h", tag, rb_idx, readback_data, rb_exp);
          else n_pass++;
          if (rb_idx == NW - 1) begin
            n_checks++;
            if (done !== 1'b1) $display("FAIL %s last_readback_in_finish: done=%b want 1", tag, done);
            else n_pass++;
          end
        end
        rb_idx++;
      end
      if (done) begin
        done_cnt++; done_cyc = cyc; finished = 1'b1;
        n_checks++;
        if ({busy, config_en, config_clk} !== 3'b100)
          $display("FAIL %s done_cycle_outputs: busy/en/clk=%b want 100", tag, {busy, config_en, config_clk});
        else n_pass++;
      end
    end
    word_valid = 1'b0; start = 1'b0;
    n_checks++;
    if (!finished) $display("FAIL %s timeout: no done after %0d cycles", tag, cyc);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL %s busy_fall: busy/done=%b want 00", tag, {busy, done});
    else n_pass++;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy || readback_valid) extra++;
    end
    n_checks++;
    if (done_cyc !== CW*2*CD + NW + stall_len)
      $display("FAIL %s latency: got %0d want %0d", tag, done_cyc, CW*2*CD + NW + stall_len);
    else n_pass++;
    n_checks++;
    if (edge_cnt - e0 !== CW) $display("FAIL %s edges: got %0d want %0d", tag, edge_cnt - e0, CW);
    else n_pass++;
    n_checks++;
    if (chain !== stream[CW-1:0]) $display("FAIL %s chain: got %h want %h", tag, chain, stream[CW-1:0]);
    else n_pass++;
    n_checks++;
    if (rb_idx !== NW || done_cnt !== 1 || extra !== 0)
      $display("FAIL %s pulses: readbacks=%0d dones=%0d stray=%0d want %0d/1/0", tag, rb_idx, done_cnt, extra, NW);
    else n_pass++;
    n_checks++;
    if (bad_in !== 0 || bad_hi !== 0)
      $display("FAIL %s protocol: config_in_changes_high=%0d ready_in_high=%0d want 0/0", tag, bad_in, bad_hi);
    else n_pass++;
    n_checks++;
    if (bad_stall !== 0 || stall_left !== 0)
      $display("FAIL %s stall: bad=%0d unserved=%0d want 0/0", tag, bad_stall, stall_left);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({word_ready, config_in, config_clk, config_en, readback_data, readback_valid, busy, done} !== '0)
      $display("FAIL reset_initial: outputs=%h want 0",
               {word_ready, config_in, config_clk, config_en, readback_data, readback_valid, busy, done});
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    do_preload(40'hFF_FFFF_FFFF);
    start = 1'b1; word_valid = 1'b1; word_data = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL busy_during_load: got %b want 1", busy);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({word_ready, config_in, config_clk, config_en, readback_data, readback_valid, busy, done} !== '0)
      $display("FAIL reset_mid_load: outputs=%h want 0",
               {word_ready, config_in, config_clk, config_en, readback_data, readback_valid, busy, done});
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; word_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, word_ready, config_en} !== 3'b000)
      $display("FAIL idle_after_reset: busy/ready/en=%b want 000", {busy, word_ready, config_en});
    else n_pass++;
  endtask

  task automatic test_basic_load();
    run_load("basic", {16'hFF81, 16'h0F0F, 16'hA5C3}, {8'($urandom), 32'($urandom)}, 0, 0, 1'b0);
    n_checks++;
    if (chain !== 40'h81_0F0F_A5C3) $display("FAIL basic_chain_const: got %h want 810f0fa5c3", chain);
    else n_pass++;
  endtask

  task automatic test_stall();
    run_load("stall", {16'hFF81, 16'h0F0F, 16'hA5C3}, {8'($urandom), 32'($urandom)}, 1, 10, 1'b0);
  endtask

  task automatic test_readback();
    run_load("readback", {16'($urandom), 32'($urandom)}, 40'h12_3456_789A, 0, 0, 1'b0);
  endtask

  task automatic test_abort();
    int e0, waited, stray;
    do_preload(40'h0);
    e0 = edge_cnt; waited = 0; stray = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; word_valid = 1'b1; word_data = 16'h5A5A;
    while (edge_cnt - e0 < 5 && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    n_checks++;
    if (edge_cnt - e0 !== 5) $display("FAIL abort_reach_edge5: edges=%0d want 5", edge_cnt - e0);
    else n_pass++;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; word_valid = 1'b0;
    n_checks++;
    if ({config_en, config_clk, word_ready, busy, done} !== 5'b0)
      $display("FAIL abort_outputs: en/clk/ready/busy/done=%b want 00000",
               {config_en, config_clk, word_ready, busy, done});
    else n_pass++;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || readback_valid || busy) stray++;
    end
    n_checks++;
    if (stray !== 0 || edge_cnt - e0 !== 5)
      $display("FAIL abort_quiet: stray=%0d edges=%0d want 0/5", stray, edge_cnt - e0);
    else n_pass++;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL abort_over_start: busy=%b want 0", busy);
    else n_pass++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; word_valid = 1'b1; word_data = 16'hDEAD; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; word_valid = 1'b0;
    n_checks++;
    if ({word_ready, busy, config_en} !== 3'b000)
      $display("FAIL abort_over_accept: ready/busy/en=%b want 000", {word_ready, busy, config_en});
    else n_pass++;
    run_load("after_abort", {16'hFF81, 16'h0F0F, 16'hA5C3}, {8'($urandom), 32'($urandom)}, 0, 0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_load("start_busy", {16'($urandom), 32'($urandom)}, {8'($urandom), 32'($urandom)}, 0, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++)
      run_load("random", {16'($urandom), 32'($urandom)}, {8'($urandom), 32'($urandom)},
               int'($urandom_range(0, NW - 1)), int'($urandom_range(0, 7)), 1'($urandom));
  endtask

  initial begin
    #12;
    test_reset();
    test_basic_load();
    test_stall();
    test_readback();
    test_abort();
    test_start_while_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
